// File: rtl/pe_bs_pkg.sv
// Shared constants and types for the barrel-shift PE drain path.
package pe_bs_pkg;

  localparam int unsigned NUM_TAPS  = 5;
  localparam int unsigned DEF_IN_W  = 16;
  localparam int unsigned DEF_OUT_W = 8;

  localparam logic [2:0] SEL_IDLE = 3'd5;
  localparam logic [2:0] SEL_LAST = 3'd4;
  localparam logic [2:0] IDX_LAST = 3'(NUM_TAPS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

endpackage

// File: rtl/pe_bs_requant.sv
// Single-tap requantizer: unsigned right shift, optional round half-up, saturate to OUT_W.
// Rounding is enabled by defining PE_BS_DRAIN_ROUND_EN.
module pe_bs_requant #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 4
) (
  input  logic [IN_W-1:0]  y,
  output logic [OUT_W-1:0] q
);

  localparam logic [IN_W:0] MaxVal = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [IN_W:0] sum;
  logic [IN_W:0] shifted;

`ifdef PE_BS_DRAIN_ROUND_EN
  // Half-LSB of the shifted result; collapses to zero when SHIFT is 0.
  localparam logic [IN_W:0] RoundVal = ((IN_W + 1)'(1) << SHIFT) >> 1;
  assign sum = {1'b0, y} + RoundVal;
`else
  assign sum = {1'b0, y};
`endif

  assign shifted = sum >> SHIFT;
  assign q       = (shifted > MaxVal) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];

endmodule

// File: rtl/pe_bs_drain.sv
// Drain stage: snapshots the five PE accumulators when sel goes 4->5 and streams them
// out requantized over valid/ready. Rounding is selected by PE_BS_DRAIN_ROUND_EN.
module pe_bs_drain
  import pe_bs_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic [IN_W-1:0]  y1,
  input  logic [IN_W-1:0]  y2,
  input  logic [IN_W-1:0]  y3,
  input  logic [IN_W-1:0]  y4,
  input  logic [IN_W-1:0]  y5,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [2:0]       sel_q;
  logic [2:0]       idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic [OUT_W-1:0] buf_q [NUM_TAPS];
  logic [OUT_W-1:0] quant [NUM_TAPS];
  logic [IN_W-1:0]  y_arr [NUM_TAPS];

  logic cap;
  logic accept;
  logic last_acc;
  logic load;

  assign y_arr[0] = y1;
  assign y_arr[1] = y2;
  assign y_arr[2] = y3;
  assign y_arr[3] = y4;
  assign y_arr[4] = y5;

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_requant
    pe_bs_requant #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_requant (
      .y (y_arr[i]),
      .q (quant[i])
    );
  end

  assign cap      = (sel == SEL_IDLE) && (sel_q == SEL_LAST);
  assign accept   = (state_q == SEND) && out_ready;
  assign last_acc = accept && (idx_q == IDX_LAST);
  // A capture is only taken when the buffer is free or freeing on this very edge.
  assign load     = cap && ((state_q == IDLE) || last_acc);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (load) begin
          idx_d = '0;
        end else begin
          if (cap) overrun_d = 1'b1;
          if (last_acc) begin
            state_d = IDLE;
            idx_d   = '0;
          end else if (accept) begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) buf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (load) begin
        for (int i = 0; i < NUM_TAPS; i++) buf_q[i] <= quant[i];
      end
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = out_valid ? buf_q[idx_q] : '0;
  assign out_last  = out_valid && (idx_q == IDX_LAST);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pe_bs_drain.sv
// Directed self-checking bench for pe_bs_drain (default SHIFT=4, OUT_W=8).
module tb_pe_bs_drain;

  logic        clk;
  logic        rst;
  logic [2:0]  sel;
  logic [15:0] y1, y2, y3, y4, y5;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int compared   = 0;
  int mismatched = 0;

  pe_bs_drain dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] data, input logic [2:0] idx);
    chk({tag, ".valid"}, 16'(out_valid), 16'd1);
    chk({tag, ".data"}, 16'(out_data), 16'(data));
    chk({tag, ".idx"}, 16'(out_idx), 16'(idx));
    chk({tag, ".last"}, 16'(out_last), 16'(idx == 3'd4));
  endtask

  task automatic set_y(input logic [15:0] a, b, c, d, e);
    y1 = a; y2 = b; y3 = c; y4 = d; y5 = e;
  endtask

  logic [7:0] exp_a [5];
  logic [7:0] exp_b [5];
  logic [7:0] exp_f [5];
  logic [7:0] exp_g [5];

  initial begin
`ifdef PE_BS_DRAIN_ROUND_EN
    exp_a = '{8'h12, 8'hF0, 8'h01, 8'h00, 8'h10};
    exp_b = '{8'h02, 8'hFF, 8'hAC, 8'hFF, 8'hFF};
`else
    exp_a = '{8'h12, 8'hF0, 8'h01, 8'h00, 8'h0F};
    exp_b = '{8'h01, 8'hFF, 8'hAB, 8'hFF, 8'hFF};
`endif
    exp_f = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    exp_g = '{8'h07, 8'hFF, 8'h55, 8'h09, 8'h0A};

    rst = 1'b1; sel = 3'd0; out_ready = 1'b0;
    set_y(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    chk("rst.valid", 16'(out_valid), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.overrun", 16'(overrun), 16'd0);
    chk("rst.data", 16'(out_data), 16'd0);
    chk("rst.idx", 16'(out_idx), 16'd0);
    chk("rst.last", 16'(out_last), 16'd0);
    rst = 1'b0;

    // sel==5 without a preceding 4, and 6/7 values: no capture.
    sel = 3'd5; tick(); tick();
    chk("nocap5.valid", 16'(out_valid), 16'd0);
    sel = 3'd6; tick(); sel = 3'd7; tick(); sel = 3'd5; tick();
    chk("nocap67.valid", 16'(out_valid), 16'd0);

    // Basic frame.
    out_ready = 1'b1;
    set_y(16'h0123, 16'h0F00, 16'h0010, 16'h0000, 16'h00FF);
    sel = 3'd4; tick();
    chk("a.pre.valid", 16'(out_valid), 16'd0);
    sel = 3'd5; tick();
    for (int i = 0; i < 5; i++) begin
      chk_beat($sformatf("a%0d", i), exp_a[i], 3'(i));
      tick();
    end
    chk("a.end.valid", 16'(out_valid), 16'd0);
    chk("a.end.busy", 16'(busy), 16'd0);

    // Saturation, snapshot hold and backpressure at idx 2.
    set_y(16'h0018, 16'h1000, 16'h0ABC, 16'hFFF8, 16'hFFFF);
    sel = 3'd4; tick();
    sel = 3'd5; tick();
    set_y(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk_beat($sformatf("b2.hold%0d", k), exp_b[2], 3'd2);
        end
        out_ready = 1'b1;
      end
      chk_beat($sformatf("b%0d", i), exp_b[i], 3'(i));
      chk("b.busy", 16'(busy), 16'd1);
      tick();
    end
    chk("b.end.valid", 16'(out_valid), 16'd0);
    chk("b.overrun", 16'(overrun), 16'd0);

    // Overrun: second capture at idx 1 is dropped.
    set_y(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500);
    sel = 3'd4; tick();
    sel = 3'd5; tick();
    chk_beat("f0", exp_f[0], 3'd0);
    sel = 3'd4; tick();
    chk_beat("f1", exp_f[1], 3'd1);
    set_y(16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0);
    sel = 3'd5; tick();
    chk("f.overrun", 16'(overrun), 16'd1);
    chk_beat("f2", exp_f[2], 3'd2);
    tick();
    chk_beat("f3", exp_f[3], 3'd3);
    // Capture lands on the accept of the idx 4 beat: seamless next frame.
    sel = 3'd4; tick();
    chk_beat("f4", exp_f[4], 3'd4);
    set_y(16'h0070, 16'h7FF0, 16'h0550, 16'h0090, 16'h00A0);
    sel = 3'd5; tick();
    for (int i = 0; i < 5; i++) begin
      chk_beat($sformatf("g%0d", i), exp_g[i], 3'(i));
      chk("g.overrun", 16'(overrun), 16'd1);
      tick();
    end
    chk("g.end.valid", 16'(out_valid), 16'd0);
    chk("g.end.overrun", 16'(overrun), 16'd1);

    // Reset mid-frame clears everything without waiting for an edge.
    set_y(16'h0123, 16'h0F00, 16'h0010, 16'h0000, 16'h00FF);
    sel = 3'd4; tick();
    sel = 3'd5; tick();
    tick();
    out_ready = 1'b0;
    chk_beat("r1", exp_a[1], 3'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("r.valid", 16'(out_valid), 16'd0);
    chk("r.busy", 16'(busy), 16'd0);
    chk("r.data", 16'(out_data), 16'd0);
    chk("r.idx", 16'(out_idx), 16'd0);
    chk("r.last", 16'(out_last), 16'd0);
    chk("r.overrun", 16'(overrun), 16'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("r.after.valid", 16'(out_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
